// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: bundles the decode-side handshake, the forwarding
// buses and the ALU-side outputs of the ID/EX operand stage.
// The master modport drives the stage inputs (decode stage, hazard unit,
// forwarding sources and the downstream consumer), and the slave modport is
// the stage itself.
interface ex_operand_stage_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    // Decode-side handshake and decoded instruction fields
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     id_rs_data;
    logic [W-1:0]     id_rt_data;
    logic [W-1:0]     id_imm;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [1:0]       id_alu_op;
    logic [5:0]       id_funct;
    logic             id_alu_src;
    logic             id_reg_write;
    logic             flush;

    // Forwarding sources from later pipeline stages
    logic             exm_reg_write;
    logic [4:0]       exm_rd;
    logic [W-1:0]     exm_result;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [W-1:0]     wb_result;

    // ALU-side handshake and operands
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_control;
    logic [W-1:0]     store_data;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             illegal;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output in_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_write, flush,
               exm_reg_write, exm_rd, exm_result,
               wb_reg_write, wb_rd, wb_result, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control, store_data,
               ex_rd, ex_reg_write, illegal, stall_count
    );

    modport slave (
        input  in_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_write, flush,
               exm_reg_write, exm_rd, exm_result,
               wb_reg_write, wb_rd, wb_result, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control, store_data,
               ex_rd, ex_reg_write, illegal, stall_count
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: single-entry ID/EX register that feeds the ALU.
// It holds one decoded instruction behind a valid/ready handshake, registers
// the decoded 3-bit ALU control, and resolves RAW hazards by forwarding from
// the EX/MEM and MEM/WB result buses. While the entry is back-pressured, the
// stored operands absorb any forwarded value so that it is not lost when the
// producing instruction retires.
module ex_operand_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_operand_stage_if.slave bus
);

    // ALU control encodings
    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    // R-type funct codes that the ALU supports
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Held entry
    logic             valid_q;
    logic [W-1:0]     rs_data_q;
    logic [W-1:0]     rt_data_q;
    logic [W-1:0]     imm_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [4:0]       rd_q;
    logic             alu_src_q;
    logic             reg_write_q;
    logic [2:0]       alu_control_q;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_count_q;

    // Handshake and decode helpers
    logic             can_accept;
    logic             capture;
    logic             stalled;
    logic [2:0]       dec_control;
    logic             dec_illegal;
    logic [W-1:0]     fwd_rs;
    logic [W-1:0]     fwd_rt;

    assign can_accept = !valid_q || bus.out_ready;
    assign capture    = bus.in_valid && can_accept && !bus.flush;
    assign stalled    = valid_q && !bus.out_ready;

    // Translate the incoming alu_op/funct pair into an ALU control code.
    // Unsupported encodings fall back to ADD and raise the illegal flag.
    always_comb begin
        dec_control = CTRL_ADD;
        dec_illegal = 1'b0;
        case (bus.id_alu_op)
            2'b00: dec_control = CTRL_ADD;
            2'b01: dec_control = CTRL_SUB;
            2'b10: begin
                case (bus.id_funct)
                    FUNCT_ADD: dec_control = CTRL_ADD;
                    FUNCT_SUB: dec_control = CTRL_SUB;
                    FUNCT_AND: dec_control = CTRL_AND;
                    FUNCT_OR:  dec_control = CTRL_OR;
                    FUNCT_SLT: dec_control = CTRL_SLT;
                    default: begin
                        dec_control = CTRL_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_control = CTRL_ADD;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Resolve the rs operand; the younger EX/MEM result beats MEM/WB, and
    // register 0 is hard-wired so it never forwards.
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_q != 5'd0) begin
            if (bus.exm_reg_write && (bus.exm_rd == rs_q)) begin
                fwd_rs = bus.exm_result;
            end else if (bus.wb_reg_write && (bus.wb_rd == rs_q)) begin
                fwd_rs = bus.wb_result;
            end
        end
    end

    // Resolve the rt operand with the same priority rules as rs.
    always_comb begin
        fwd_rt = rt_data_q;
        if (rt_q != 5'd0) begin
            if (bus.exm_reg_write && (bus.exm_rd == rt_q)) begin
                fwd_rt = bus.exm_result;
            end else if (bus.wb_reg_write && (bus.wb_rd == rt_q)) begin
                fwd_rt = bus.wb_result;
            end
        end
    end

    // Entry valid bit: flush beats everything, then capture, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Entry payload: load on capture, otherwise fold forwarded operands back
    // into storage while stalled so they outlive their producers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            alu_control_q <= CTRL_AND;
            illegal_q     <= 1'b0;
        end else if (capture) begin
            rs_data_q     <= bus.id_rs_data;
            rt_data_q     <= bus.id_rt_data;
            imm_q         <= bus.id_imm;
            rs_q          <= bus.id_rs;
            rt_q          <= bus.id_rt;
            rd_q          <= bus.id_rd;
            alu_src_q     <= bus.id_alu_src;
            reg_write_q   <= bus.id_reg_write;
            alu_control_q <= dec_control;
            illegal_q     <= dec_illegal;
        end else if (stalled && !bus.flush) begin
            rs_data_q     <= fwd_rs;
            rt_data_q     <= fwd_rt;
        end
    end

    // Saturating count of cycles in which a valid entry was held back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (stalled && (stall_count_q != CNT_MAX)) begin
            stall_count_q <= stall_count_q + CNT_ONE;
        end
    end

    assign bus.in_ready     = can_accept;
    assign bus.out_valid    = valid_q;
    assign bus.alu_a        = fwd_rs;
    assign bus.alu_b        = alu_src_q ? imm_q : fwd_rt;
    assign bus.store_data   = fwd_rt;
    assign bus.alu_control  = alu_control_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = reg_write_q;
    assign bus.illegal      = illegal_q;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus randomized traffic for the
// ID/EX operand stage, checked every cycle against a behavioural model.
module tb_ex_operand_stage;
    localparam int W     = 32;
    localparam int CNT_W = 16;

    localparam logic [5:0] FUNCT_TAB [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    localparam logic [2:0] CTRL_TAB  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.W(W), .CNT_W(CNT_W)) bus ();

    ex_operand_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model of the held entry
    logic             m_valid;
    logic [W-1:0]     m_rs_data, m_rt_data, m_imm;
    logic [4:0]       m_rs, m_rt, m_rd;
    logic             m_src, m_rw, m_ill;
    logic [2:0]       m_ctrl;
    logic [CNT_W-1:0] m_stall;

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_valid = 0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_src = 0; m_rw = 0;
        m_ill = 0; m_ctrl = 3'b000; m_stall = '0;
    endtask

    task automatic decodeModel(input logic [1:0] op, input logic [5:0] f,
                               output logic [2:0] c, output logic il);
        c  = 3'b010;
        il = 1'b0;
        if (op == 2'b01) c = 3'b110;
        else if (op == 2'b11) il = 1'b1;
        else if (op == 2'b10) begin
            il = 1'b1;
            for (int i = 0; i < 5; i++)
                if (f == FUNCT_TAB[i]) begin
                    c  = CTRL_TAB[i];
                    il = 1'b0;
                end
        end
    endtask

    function automatic logic [W-1:0] fwdModel(input logic [4:0] r, input logic [W-1:0] stored);
        if (r != 0 && bus.exm_reg_write && bus.exm_rd == r) return bus.exm_result;
        if (r != 0 && bus.wb_reg_write && bus.wb_rd == r) return bus.wb_result;
        return stored;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic updateModel();
        logic [W-1:0] fa, fb;
        logic acc, stl, il;
        logic [2:0] c;
        fa  = fwdModel(m_rs, m_rs_data);
        fb  = fwdModel(m_rt, m_rt_data);
        stl = m_valid && !bus.out_ready;
        acc = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
        if (stl && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
        if (acc) begin
            decodeModel(bus.id_alu_op, bus.id_funct, c, il);
            m_rs_data = bus.id_rs_data; m_rt_data = bus.id_rt_data; m_imm = bus.id_imm;
            m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
            m_src = bus.id_alu_src; m_rw = bus.id_reg_write; m_ctrl = c; m_ill = il;
        end else if (stl && !bus.flush) begin
            m_rs_data = fa;
            m_rt_data = fb;
        end
        if (bus.flush) m_valid = 0;
        else if (acc) m_valid = 1;
        else if (bus.out_ready) m_valid = 0;
    endtask

    task automatic checkAll();
        logic [W-1:0] fb;
        fb = fwdModel(m_rt, m_rt_data);
        checkOutput("out_valid", bus.out_valid, m_valid);
        checkOutput("in_ready", bus.in_ready, !m_valid || bus.out_ready);
        checkOutput("alu_a", bus.alu_a, fwdModel(m_rs, m_rs_data));
        checkOutput("alu_b", bus.alu_b, m_src ? m_imm : fb);
        checkOutput("store_data", bus.store_data, fb);
        checkOutput("alu_control", bus.alu_control, m_ctrl);
        checkOutput("illegal", bus.illegal, m_ill);
        checkOutput("ex_rd", bus.ex_rd, m_rd);
        checkOutput("ex_reg_write", bus.ex_reg_write, m_rw);
        checkOutput("stall_count", bus.stall_count, m_stall);
    endtask

    // Check the current cycle, clock it, update the model, return at negedge
    task automatic step();
        #1;
        checkAll();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [W-1:0] rsData, input logic [W-1:0] rtData,
                                 input logic [W-1:0] imm, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [1:0] op, input logic [5:0] funct,
                                 input logic src);
        bus.in_valid = 1; bus.id_rs_data = rsData; bus.id_rt_data = rtData;
        bus.id_imm = imm; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_alu_op = op; bus.id_funct = funct; bus.id_alu_src = src;
        bus.id_reg_write = (rd != 0);
    endtask

    task automatic quietInputs();
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
        bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_alu_op = '0;
        bus.id_funct = '0; bus.id_alu_src = 0; bus.id_reg_write = 0;
        bus.exm_reg_write = 0; bus.exm_rd = '0; bus.exm_result = '0;
        bus.wb_reg_write = 0; bus.wb_rd = '0; bus.wb_result = '0;
    endtask

    task automatic doReset();
        rst_n = 0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        quietInputs();
        rst_n = 0;
        modelReset();
        @(negedge clk);
        #1;
        checkOutput("reset in_ready", bus.in_ready, 1'b1);
        checkOutput("reset alu_control", bus.alu_control, 3'b000);
        checkAll();
        @(negedge clk);
        rst_n = 1;

        // ADD R-type without hazards
        bus.out_ready = 1;
        applyStimulus(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 2'b10, 6'h20, 1'b0);
        step();
        bus.in_valid = 0;
        #1;
        checkOutput("add out_valid", bus.out_valid, 1'b1);
        checkOutput("add alu_a", bus.alu_a, 32'd5);
        checkOutput("add alu_b", bus.alu_b, 32'd7);
        checkOutput("add alu_control", bus.alu_control, 3'b010);
        step();

        // Forwarding priority and register-zero exclusion
        applyStimulus(32'h99, 32'h1, 32'd0, 5'd3, 5'd4, 5'd6, 2'b00, 6'h0, 1'b0);
        step();
        bus.in_valid = 0;
        bus.exm_reg_write = 1; bus.exm_rd = 3; bus.exm_result = 32'h11;
        bus.wb_reg_write = 1; bus.wb_rd = 3; bus.wb_result = 32'h22;
        #1;
        checkOutput("fwd exm priority", bus.alu_a, 32'h11);
        bus.exm_reg_write = 0;
        #1;
        checkOutput("fwd wb", bus.alu_a, 32'h22);
        step();
        quietInputs();
        bus.out_ready = 1;
        applyStimulus(32'h77, 32'h1, 32'd0, 5'd0, 5'd4, 5'd6, 2'b00, 6'h0, 1'b0);
        step();
        bus.in_valid = 0;
        bus.exm_reg_write = 1; bus.exm_rd = 0; bus.exm_result = 32'h11;
        bus.wb_reg_write = 1; bus.wb_rd = 0; bus.wb_result = 32'h22;
        #1;
        checkOutput("fwd rs zero", bus.alu_a, 32'h77);
        step();

        // Back-pressure with operand refresh
        quietInputs();
        doReset();
        bus.out_ready = 1;
        applyStimulus(32'h1, 32'h10, 32'd0, 5'd1, 5'd5, 5'd7, 2'b01, 6'h0, 1'b0);
        step();
        quietInputs();
        bus.wb_reg_write = 1; bus.wb_rd = 5; bus.wb_result = 32'h55;
        step();
        bus.wb_reg_write = 0;
        applyStimulus(32'hAA, 32'hBB, 32'd0, 5'd2, 5'd2, 5'd2, 2'b00, 6'h0, 1'b0);
        step();
        step();
        #1;
        checkOutput("refresh alu_b", bus.alu_b, 32'h55);
        checkOutput("stall in_ready", bus.in_ready, 1'b0);
        checkOutput("stall_count 3", bus.stall_count, 16'd3);
        bus.in_valid = 0;
        bus.out_ready = 1;
        step();

        // Immediate operand and illegal funct
        applyStimulus(32'h3, 32'h4, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3, 2'b00, 6'h0, 1'b1);
        step();
        applyStimulus(32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'h00, 1'b0);
        #1;
        checkOutput("imm alu_b", bus.alu_b, 32'hFFFFFFFC);
        checkOutput("imm alu_control", bus.alu_control, 3'b010);
        step();
        bus.in_valid = 0;
        bus.out_ready = 0;
        #1;
        checkOutput("illegal flag", bus.illegal, 1'b1);
        checkOutput("illegal alu_control", bus.alu_control, 3'b010);
        step();

        // Flush a held entry while a new instruction is offered
        applyStimulus(32'h8, 32'h9, 32'h0, 5'd1, 5'd2, 5'd9, 2'b00, 6'h0, 1'b0);
        bus.flush = 1;
        bus.out_ready = 1;
        step();
        bus.flush = 0;
        bus.in_valid = 0;
        bus.out_ready = 0;
        #1;
        checkOutput("flush out_valid", bus.out_valid, 1'b0);
        checkOutput("flush drop ex_rd", bus.ex_rd, 5'd3);
        step();

        // Asynchronous reset in the middle of a stall
        applyStimulus(32'h8, 32'h9, 32'h0, 5'd1, 5'd2, 5'd9, 2'b01, 6'h0, 1'b0);
        step();
        bus.in_valid = 0;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        modelReset();
        checkOutput("rst out_valid", bus.out_valid, 1'b0);
        checkOutput("rst alu_a", bus.alu_a, 32'd0);
        checkOutput("rst stall_count", bus.stall_count, 16'd0);
        checkAll();
        @(negedge clk);
        rst_n = 1;

        // Streaming eight instructions back to back
        bus.out_ready = 1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) applyStimulus(i, i + 100, 0, 5'd1, 5'd2, 5'(i + 1), 2'b00, 6'h0, 1'b0);
            else bus.in_valid = 0;
            #1;
            if (i > 0) begin
                checkOutput("stream out_valid", bus.out_valid, 1'b1);
                checkOutput("stream ex_rd", bus.ex_rd, 64'(i));
            end
            step();
        end
        checkOutput("stream stall_count", bus.stall_count, 16'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bus.in_valid      = ($urandom_range(0, 3) != 0);
            bus.id_rs_data    = $urandom;
            bus.id_rt_data    = $urandom;
            bus.id_imm        = $urandom;
            bus.id_rs         = 5'($urandom_range(0, 3));
            bus.id_rt         = 5'($urandom_range(0, 3));
            bus.id_rd         = 5'($urandom_range(0, 3));
            bus.id_alu_op     = 2'($urandom_range(0, 3));
            bus.id_funct      = ($urandom_range(0, 4) == 0) ? 6'($urandom) : FUNCT_TAB[$urandom_range(0, 4)];
            bus.id_alu_src    = 1'($urandom);
            bus.id_reg_write  = 1'($urandom);
            bus.flush         = ($urandom_range(0, 9) == 0);
            bus.out_ready     = ($urandom_range(0, 2) != 0);
            bus.exm_reg_write = 1'($urandom);
            bus.exm_rd        = 5'($urandom_range(0, 3));
            bus.exm_result    = $urandom;
            bus.wb_reg_write  = 1'($urandom);
            bus.wb_rd         = 5'($urandom_range(0, 3));
            bus.wb_result     = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
